// File: rtl/rx_frame_fifo.sv
// rx_frame_fifo: receive-side frame buffer between the RX decode pipeline
// and the client interface. Incoming words are written into one dual-pointer
// RAM FIFO. A frame becomes readable only after the CRC checker passes it.
// Frames that fail CRC, overflow, or are abandoned are rewound out of the
// FIFO and never reach the client.
//
// Ports:
//   rxclk          receive clock, all logic on the rising edge
//   reset          synchronous, active-high reset
//   rxd_in         data word, aligned to receiving_dly
//   rxc_in         per-byte valid for rxd_in
//   receiving      high while a frame is being received (undelayed)
//   crc_done       one-cycle pulse, CRC verdict available
//   crc_ok         CRC verdict, sampled only with crc_done
//   rx_data        client data word
//   rx_data_valid  client per-byte valid; all-zero means no word
//   rx_good_frame  one-cycle pulse, frame committed
//   rx_bad_frame   one-cycle pulse, frame discarded
//   receiving_dly  receiving delayed WR_DLY cycles (write enable)
//   fifo_overflow  sticky for the current frame; set on a write attempt when full
module rx_frame_fifo #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned CTRL_W     = 8,
  parameter int unsigned DEPTH_LOG2 = 9,
  parameter int unsigned WR_DLY     = 2
) (
  input  logic              rxclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] rxd_in,
  input  logic [CTRL_W-1:0] rxc_in,
  input  logic              receiving,
  input  logic              crc_done,
  input  logic              crc_ok,
  output logic [DATA_W-1:0] rx_data,
  output logic [CTRL_W-1:0] rx_data_valid,
  output logic              rx_good_frame,
  output logic              rx_bad_frame,
  output logic              receiving_dly,
  output logic              fifo_overflow
);

  localparam int unsigned PTR_W  = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned WORD_W = DATA_W + CTRL_W;

  typedef enum logic [1:0] {IDLE, WRITE, WAIT_CRC} state_t;

  state_t             state, state_n;
  logic [WR_DLY-1:0]  dly_sr;
  logic               dly_prev;
  logic               rise, fall;
  logic [PTR_W-1:0]   wr_ptr, commit_ptr, rd_ptr;
  logic [PTR_W-1:0]   wr_base, wr_ptr_n, commit_ptr_n;
  logic               full, rd_en;
  logic               do_commit, do_rewind, start, wr_frame;
  logic               ovf_eff, attempt, we, ovf_n;
  logic [WORD_W-1:0]  ram [DEPTH];

  assign receiving_dly = dly_sr[WR_DLY-1];
  assign rise          = receiving_dly & ~dly_prev;
  assign fall          = ~receiving_dly & dly_prev;
  assign full          = (wr_ptr - rd_ptr) == PTR_W'(DEPTH);
  assign rd_en         = rd_ptr != commit_ptr;

  always_comb begin
    state_n   = state;
    do_commit = 1'b0;
    do_rewind = 1'b0;
    start     = 1'b0;
    wr_frame  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = WRITE;
          start   = 1'b1;
        end
      end
      WRITE: begin
        wr_frame = 1'b1;
        if (fall) state_n = WAIT_CRC;
      end
      WAIT_CRC: begin
        if (crc_done) begin
          if (crc_ok && !fifo_overflow) do_commit = 1'b1;
          else                          do_rewind = 1'b1;
          state_n = IDLE;
        end
        // A new frame arriving here: apply any same-cycle verdict first,
        // otherwise the pending frame is abandoned and rewound.
        if (rise) begin
          if (!crc_done) do_rewind = 1'b1;
          state_n = WRITE;
          start   = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // The first word of a new frame is written in the same cycle as the
  // rising edge, on top of the pointer left by a rewind if one happens.
  always_comb begin
    ovf_eff      = start ? 1'b0 : fifo_overflow;
    wr_base      = do_rewind ? commit_ptr : wr_ptr;
    attempt      = receiving_dly & (wr_frame | start) & ~ovf_eff;
    we           = attempt & ~full;
    ovf_n        = ovf_eff | (attempt & full);
    wr_ptr_n     = wr_base + PTR_W'(we);
    commit_ptr_n = do_commit ? wr_ptr : commit_ptr;
  end

  always_ff @(posedge rxclk) begin
    if (we) ram[wr_base[DEPTH_LOG2-1:0]] <= {rxd_in, rxc_in};
  end

  always_ff @(posedge rxclk) begin
    if (reset) begin
      state         <= IDLE;
      dly_sr        <= '0;
      dly_prev      <= 1'b0;
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      fifo_overflow <= 1'b0;
      rx_good_frame <= 1'b0;
      rx_bad_frame  <= 1'b0;
      rx_data       <= '0;
      rx_data_valid <= '0;
    end else begin
      state     <= state_n;
      dly_sr[0] <= receiving;
      for (int unsigned i = 1; i < WR_DLY; i++) dly_sr[i] <= dly_sr[i-1];
      dly_prev      <= receiving_dly;
      wr_ptr        <= wr_ptr_n;
      commit_ptr    <= commit_ptr_n;
      fifo_overflow <= ovf_n;
      rx_good_frame <= do_commit;
      rx_bad_frame  <= do_rewind;
      if (rd_en) begin
        rx_data       <= ram[rd_ptr[DEPTH_LOG2-1:0]][WORD_W-1:CTRL_W];
        rx_data_valid <= ram[rd_ptr[DEPTH_LOG2-1:0]][CTRL_W-1:0];
        rd_ptr        <= rd_ptr + PTR_W'(1);
      end else begin
        rx_data_valid <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Self-checking bench for rx_frame_fifo (DEPTH_LOG2=2, WR_DLY=2).
// Stimulus words are queued per frame and presented when the bench's own
// two-cycle copy of receiving is high; words of frames expected to commit
// are pushed to a scoreboard and popped by a negedge output monitor.
module tb_rx_frame_fifo;

  localparam int unsigned DATA_W     = 64;
  localparam int unsigned CTRL_W     = 8;
  localparam int unsigned DEPTH_LOG2 = 2;
  localparam int unsigned WR_DLY     = 2;

  logic              rxclk = 1'b0;
  logic              reset;
  logic [DATA_W-1:0] rxd_in;
  logic [CTRL_W-1:0] rxc_in;
  logic              receiving, crc_done, crc_ok;
  logic [DATA_W-1:0] rx_data;
  logic [CTRL_W-1:0] rx_data_valid;
  logic              rx_good_frame, rx_bad_frame, receiving_dly, fifo_overflow;

  rx_frame_fifo #(
    .DATA_W(DATA_W), .CTRL_W(CTRL_W), .DEPTH_LOG2(DEPTH_LOG2), .WR_DLY(WR_DLY)
  ) dut (
    .rxclk(rxclk), .reset(reset), .rxd_in(rxd_in), .rxc_in(rxc_in),
    .receiving(receiving), .crc_done(crc_done), .crc_ok(crc_ok),
    .rx_data(rx_data), .rx_data_valid(rx_data_valid),
    .rx_good_frame(rx_good_frame), .rx_bad_frame(rx_bad_frame),
    .receiving_dly(receiving_dly), .fifo_overflow(fifo_overflow)
  );

  always #5 rxclk = ~rxclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int good_cnt = 0;
  int bad_cnt = 0;
  int wcount = 0;
  int done_cyc = 0;
  bit mon_en = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0;
  logic [DEPTH_LOG2:0] exp_ptr = '0;
  logic [DATA_W+CTRL_W-1:0] stim_q[$];
  logic [DATA_W+CTRL_W-1:0] exp_q[$];
  int out_cyc[$];

  always @(posedge rxclk) cyc <= cyc + 1;

  always @(negedge rxclk) begin
    if (mon_en && !reset) begin
      if (rx_good_frame === 1'b1) good_cnt++;
      if (rx_bad_frame === 1'b1) bad_cnt++;
      if (rx_data_valid !== '0) begin
        logic [DATA_W+CTRL_W-1:0] e;
        checks++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word: got %h/%h want no word", rx_data, rx_data_valid);
        end else begin
          e = exp_q.pop_front();
          if ({rx_data, rx_data_valid} !== e) begin
            errors++;
            $display("FAIL data_word: got %h/%h want %h/%h",
                     rx_data, rx_data_valid, e[DATA_W+CTRL_W-1:CTRL_W], e[CTRL_W-1:0]);
          end
        end
      end
    end
  end

  task automatic step(input logic r, input logic d, input logic ok);
    logic rdly;
    logic [DATA_W+CTRL_W-1:0] w;
    @(posedge rxclk); #1;
    receiving = r; crc_done = d; crc_ok = ok;
    rdly = h2; h2 = h1; h1 = r;
    if (rdly && stim_q.size() != 0) begin
      w = stim_q.pop_front();
      rxd_in = w[DATA_W+CTRL_W-1:CTRL_W];
      rxc_in = w[CTRL_W-1:0];
      wcount++;
    end else begin
      rxd_in = '0;
      rxc_in = '0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0);
  endtask

  task automatic load_frame(input int n, input logic [DATA_W-1:0] base, input bit good);
    logic [DATA_W+CTRL_W-1:0] w;
    for (int i = 0; i < n; i++) begin
      w = {base + DATA_W'(i), (i == n - 1) ? 8'h0F : 8'hFF};
      stim_q.push_back(w);
      if (good) exp_q.push_back(w);
    end
    if (good) exp_ptr = exp_ptr + (DEPTH_LOG2 + 1)'(n);
  endtask

  task automatic check_counts(input string name, input int g0, input int b0,
                              input int dg, input int db, input int nout);
    checks++;
    if (good_cnt - g0 !== dg) begin
      errors++;
      $display("FAIL %s_good: got %0d want %0d", name, good_cnt - g0, dg);
    end
    checks++;
    if (bad_cnt - b0 !== db) begin
      errors++;
      $display("FAIL %s_bad: got %0d want %0d", name, bad_cnt - b0, db);
    end
    checks++;
    if (out_cyc.size() !== nout || exp_q.size() !== 0) begin
      errors++;
      $display("FAIL %s_words: got %0d out %0d left want %0d out 0 left",
               name, out_cyc.size(), exp_q.size(), nout);
    end
    checks++;
    if (dut.wr_ptr !== exp_ptr || dut.commit_ptr !== exp_ptr || dut.rd_ptr !== exp_ptr) begin
      errors++;
      $display("FAIL %s_ptrs: got wr=%0d commit=%0d rd=%0d want %0d",
               name, dut.wr_ptr, dut.commit_ptr, dut.rd_ptr, exp_ptr);
    end
  endtask

  task automatic check_outputs_zero(input string name);
    checks++;
    if (rx_data !== '0 || rx_data_valid !== '0 || rx_good_frame !== 1'b0 ||
        rx_bad_frame !== 1'b0 || receiving_dly !== 1'b0 || fifo_overflow !== 1'b0) begin
      errors++;
      $display("FAIL %s_outputs: got data=%h valid=%h good=%b bad=%b dly=%b ovf=%b want all 0",
               name, rx_data, rx_data_valid, rx_good_frame, rx_bad_frame,
               receiving_dly, fifo_overflow);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; receiving = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
    rxd_in = '0; rxc_in = '0;
    repeat (2) @(posedge rxclk);
    #1 reset = 1'b0;
    check_outputs_zero("reset");
    checks++;
    if (dut.wr_ptr !== '0 || dut.commit_ptr !== '0 || dut.rd_ptr !== '0) begin
      errors++;
      $display("FAIL reset_ptrs: got %0d/%0d/%0d want 0/0/0", dut.wr_ptr, dut.commit_ptr, dut.rd_ptr);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_good_frame();
    int g0 = good_cnt, b0 = bad_cnt;
    out_cyc.delete();
    load_frame(4, 64'hA0A0_0000_1111_0000, 1'b1);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    done_cyc = cyc;
    idle(12);
    check_counts("good", g0, b0, 1, 0, 4);
    checks++;
    if (out_cyc.size() != 4 || out_cyc[0] !== done_cyc + 2 || out_cyc[3] !== done_cyc + 5) begin
      errors++;
      $display("FAIL good_latency: got first=%0d last=%0d want %0d %0d",
               (out_cyc.size() > 0) ? out_cyc[0] : -1,
               (out_cyc.size() > 3) ? out_cyc[3] : -1, done_cyc + 2, done_cyc + 5);
    end
  endtask

  task automatic test_bad_crc();
    int g0 = good_cnt, b0 = bad_cnt;
    out_cyc.delete();
    load_frame(4, 64'hBAD0_0000_2222_0000, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(12);
    check_counts("badcrc", g0, b0, 0, 1, 0);
  endtask

  task automatic test_overflow();
    int g0 = good_cnt, b0 = bad_cnt, prev;
    out_cyc.delete();
    wcount = 0;
    load_frame(6, 64'h0F0F_0000_3333_0000, 1'b0);
    for (int i = 0; i < 9; i++) begin
      prev = wcount;
      step(i < 6, 1'b0, 1'b0);
      if (wcount == 5 && prev == 4) begin
        checks++;
        if (fifo_overflow !== 1'b0) begin
          errors++;
          $display("FAIL ovf_word5_pre: got %b want 0", fifo_overflow);
        end
      end
      if (wcount == 6 && prev == 5) begin
        checks++;
        if (fifo_overflow !== 1'b1) begin
          errors++;
          $display("FAIL ovf_after_word5: got %b want 1", fifo_overflow);
        end
      end
    end
    step(1'b0, 1'b1, 1'b1);
    idle(12);
    check_counts("ovf", g0, b0, 0, 1, 0);
    g0 = good_cnt; b0 = bad_cnt;
    out_cyc.delete();
    load_frame(2, 64'h600D_0000_4444_0000, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    idle(3);
    checks++;
    if (fifo_overflow !== 1'b0) begin
      errors++;
      $display("FAIL ovf_cleared: got %b want 0", fifo_overflow);
    end
    step(1'b0, 1'b1, 1'b1);
    idle(12);
    check_counts("after_ovf", g0, b0, 1, 0, 2);
  endtask

  task automatic test_back_to_back();
    int g0 = good_cnt, b0 = bad_cnt;
    out_cyc.delete();
    load_frame(3, 64'hAAAA_0000_5555_0000, 1'b1);
    load_frame(2, 64'hBBBB_0000_6666_0000, 1'b0);
    repeat (3) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    idle(3);
    step(1'b0, 1'b1, 1'b0);
    idle(12);
    check_counts("b2b", g0, b0, 1, 1, 3);
  endtask

  task automatic test_abandon();
    int g0 = good_cnt, b0 = bad_cnt;
    out_cyc.delete();
    load_frame(2, 64'hDEAD_0000_7777_0000, 1'b0);
    load_frame(2, 64'hC0DE_0000_8888_0000, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    idle(3);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    idle(12);
    check_counts("abandon", g0, b0, 1, 1, 2);
  endtask

  task automatic test_reset_mid_frame();
    int g0 = good_cnt, b0 = bad_cnt;
    out_cyc.delete();
    wcount = 0;
    load_frame(4, 64'hEEEE_0000_9999_0000, 1'b0);
    for (int i = 0; i < 8 && wcount < 2; i++) step(1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    @(posedge rxclk); #1;
    reset = 1'b0; receiving = 1'b0; crc_done = 1'b0; crc_ok = 1'b0;
    rxd_in = '0; rxc_in = '0;
    h1 = 1'b0; h2 = 1'b0;
    stim_q.delete();
    exp_ptr = '0;
    check_outputs_zero("midreset");
    load_frame(2, 64'h1234_0000_AAAA_0000, 1'b1);
    repeat (2) step(1'b1, 1'b0, 1'b0);
    idle(3);
    step(1'b0, 1'b1, 1'b1);
    idle(12);
    check_counts("midreset", g0, b0, 1, 0, 2);
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_crc();
    test_overflow();
    test_back_to_back();
    test_abandon();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rx_frame_fifo.md
Name: rx_frame_fifo

Overview:
Parametrised receive-side frame buffer between the RX decode pipeline and the client interface.
- Buffers data and lane-valid words in one internal dual-pointer RAM FIFO; no vendor FIFO cores.
- Releases a frame to the client only after the CRC checker passes it. Frames that fail CRC, overflow, or are abandoned are rewound out of the FIFO and never reach the client.

Parameters:
DATA_W, 64, data word width in bits (multiple of 8)
CTRL_W, 8, lane-valid width; must equal DATA_W/8
DEPTH_LOG2, 9, log2 of FIFO depth in words (DEPTH = 2**DEPTH_LOG2)
WR_DLY, 2, pipeline delay in cycles from receiving to write enable (1..4)

Ports:
rxclk  in  1  receive clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rxd_in  in  DATA_W  data word, already aligned to delayed write enable
rxc_in  in  CTRL_W  per-byte valid for rxd_in
receiving  in  1  high while a frame is being received (undelayed)
crc_done  in  1  one-cycle pulse, CRC verdict available
crc_ok  in  1  CRC verdict, sampled only when crc_done=1
rx_data  out  DATA_W  client data word
rx_data_valid  out  CTRL_W  client per-byte valid; all-zero means no word
rx_good_frame  out  1  one-cycle pulse, frame committed
rx_bad_frame  out  1  one-cycle pulse, frame discarded
receiving_dly  out  1  receiving delayed WR_DLY cycles (write enable)
fifo_overflow  out  1  sticky for current frame; set on write attempt when full

Behaviour:
- Reset: one clock, synchronous, active-high. All pointers = 0, state IDLE, delay line cleared. Every output = 0, including rx_data.
- Reset mid-frame abandons all stored and in-flight data without emitting rx_bad_frame.
- Pointers: wr_ptr, commit_ptr and rd_ptr are each DEPTH_LOG2+1 bits and wrap modulo 2**(DEPTH_LOG2+1).
  - full when wr_ptr - rd_ptr == DEPTH.
  - readable when rd_ptr != commit_ptr.
- Write enable: receiving_dly is a WR_DLY-stage shift of receiving.
  - A word {rxd_in, rxc_in} is written when receiving_dly=1, state=WRITE, full=0 and fifo_overflow=0.
  - Writing increments wr_ptr.
- State machine: IDLE, WRITE, WAIT_CRC.
  - IDLE -> WRITE on rising edge of receiving_dly. fifo_overflow is cleared in the same cycle, and that cycle's word is written.
  - WRITE -> WAIT_CRC on falling edge of receiving_dly.
  - WAIT_CRC, crc_done=1, crc_ok=1, fifo_overflow=0: commit_ptr <= wr_ptr; rx_good_frame=1 next cycle; -> IDLE.
  - WAIT_CRC, crc_done=1, and crc_ok=0 or fifo_overflow=1: wr_ptr <= commit_ptr (rewind); rx_bad_frame=1 next cycle; -> IDLE.
  - WAIT_CRC, rising edge of receiving_dly with no crc_done in that cycle: rewind, rx_bad_frame=1, -> WRITE, and the new frame's first word is written.
  - WAIT_CRC, crc_done and rising edge in the same cycle: the verdict is applied first (commit or rewind), then -> WRITE and the first word is written after the new wr_ptr.
  - crc_done in IDLE or WRITE is ignored.
- Overflow: a write attempt while full sets fifo_overflow. Further writes of that frame are suppressed, and the frame is always discarded at its verdict.
- Read side:
  - Read fires when readable; one word per cycle, never stalls, no client backpressure.
  - Latency 1 cycle: rx_data and rx_data_valid are registered from RAM[rd_ptr], and rd_ptr increments.
  - When not reading, rx_data_valid=0 and rx_data holds its last value.
- Committed words stream out starting the cycle after commit_ptr updates. A committed frame's first word appears 2 cycles after crc_done.
- Zero-length frame: receiving_dly high with no writes (overflow from the first word) is discarded as bad. A zero-word commit is legal and still pulses rx_good_frame.
- Simultaneous read and write in one cycle are both honoured. full is evaluated on pre-update pointers.

Test Plan:
- Good frame, WR_DLY=2: receiving high 4 cycles with words D0..D3 (rxc=FF, FF, FF, 0F); crc_done+crc_ok 3 cycles after fall -> rx_good_frame pulse; D0..D3 appear on 4 consecutive cycles starting 2 cycles after crc_done, valids FF, FF, FF, 0F.
- Bad CRC: same 4-word frame, crc_ok=0 -> rx_bad_frame pulse; rx_data_valid stays 00; wr_ptr equals commit_ptr afterwards.
- Overflow, DEPTH_LOG2=2: 6-word frame with crc_ok=1 -> fifo_overflow=1 at word 5; rx_bad_frame; no output. Following 2-word good frame is delivered intact.
- Back-to-back: frame A (3 words, good) then frame B (2 words, bad), with crc_done for A coinciding with B's rising edge -> only A's 3 words are output, then B is rewound.
- Abandon: a new frame starts in WAIT_CRC without crc_done -> rx_bad_frame on the previous frame; the new frame commits normally on its own verdict.
- Reset mid-frame: assert reset during word 2 of a frame, then send a 2-word good frame -> all outputs 0 after reset; only the 2 new words are delivered.
